// File: rtl/systolic_array_ctrl.sv
// Run sequencer for a weight-stationary ROWS x COLS PE array: clear, load weight rows,
// stream activation vectors, drain the partial-sum pipeline, then pulse done.
module systolic_array_ctrl #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [CNT_W-1:0]                     cfg_num_vec,
    input  logic                                 w_valid,
    output logic                                 w_ready,
    output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] w_row_idx,
    output logic                                 act_rd_en,
    output logic [CNT_W-1:0]                     act_idx,
    output logic                                 pe_clear_weight,
    output logic                                 pe_weight_shift,
    output logic                                 pe_mac_enable,
    output logic [COLS-1:0]                      res_col_valid,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned HW = ROWS + COLS - 2;

    typedef enum logic [2:0] {
        StIdle, StClear, StLoad, StCompute, StDrain, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   num_vec_q, num_vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]      row_q, row_d;
    logic [HW-1:0]      hist_q, hist_d;
    logic               w_ready_q, w_ready_d;
    logic               act_rd_en_q, act_rd_en_d;
    logic [CNT_W-1:0]   act_idx_q, act_idx_d;
    logic               clear_q, clear_d;
    logic               mac_q, mac_d;
    logic [COLS-1:0]    res_q, res_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               beat;

    // Shift must coincide with the row on the bus, so it is gated by the live w_valid.
    assign beat = w_valid & w_ready_q;

    always_comb begin
        state_d   = state_q;
        num_vec_d = num_vec_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    num_vec_d = cfg_num_vec;
                    state_d   = StClear;
                end
            end
            StClear: begin
                row_d   = '0;
                state_d = StLoad;
            end
            StLoad: begin
                if (beat) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        cnt_d   = '0;
                        state_d = (num_vec_q == '0) ? StDone : StCompute;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            StCompute: begin
                if (cnt_q == num_vec_q - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDrain: begin
                if (cnt_q == CNT_W'(ROWS + COLS - 2)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // History of act_rd_en; column c sees the stream ROWS+c cycles after it was read.
        hist_d[0] = act_rd_en_q;
        for (int k = 1; k < HW; k++) begin
            hist_d[k] = hist_q[k-1];
        end
        for (int c = 0; c < COLS; c++) begin
            res_d[c] = hist_q[ROWS+c-2];
        end

        clear_d = (state_d == StClear);
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            cnt_d   = '0;
            row_d   = '0;
            hist_d  = '0;
            res_d   = '0;
            clear_d = 1'b1;
        end

        w_ready_d   = (state_d == StLoad);
        act_rd_en_d = (state_d == StCompute);
        act_idx_d   = act_rd_en_d ? cnt_d : '0;
        mac_d       = (state_d == StCompute) || (state_d == StDrain);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            num_vec_q   <= '0;
            cnt_q       <= '0;
            row_q       <= '0;
            hist_q      <= '0;
            w_ready_q   <= 1'b0;
            act_rd_en_q <= 1'b0;
            act_idx_q   <= '0;
            clear_q     <= 1'b0;
            mac_q       <= 1'b0;
            res_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            hist_q      <= hist_d;
            w_ready_q   <= w_ready_d;
            act_rd_en_q <= act_rd_en_d;
            act_idx_q   <= act_idx_d;
            clear_q     <= clear_d;
            mac_q       <= mac_d;
            res_q       <= res_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign w_ready         = w_ready_q;
    assign w_row_idx       = row_q;
    assign act_rd_en       = act_rd_en_q;
    assign act_idx         = act_idx_q;
    assign pe_clear_weight = clear_q;
    assign pe_weight_shift = beat;
    assign pe_mac_enable   = mac_q;
    assign res_col_valid   = res_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl: stimulus pushes expected events (cycle, value),
// a negedge monitor pops and compares whenever the DUT presents an event.
module tb_systolic_array_ctrl;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned RW    = 2;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] cfg_num_vec = '0;
    logic             w_valid = 1'b1;
    logic             w_ready;
    logic [RW-1:0]    w_row_idx;
    logic             act_rd_en;
    logic [CNT_W-1:0] act_idx;
    logic             pe_clear_weight;
    logic             pe_weight_shift;
    logic             pe_mac_enable;
    logic [COLS-1:0]  res_col_valid;
    logic             busy;
    logic             done;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  mac_cnt = 0;
    ev_t clr_q[$];
    ev_t shf_q[$];
    ev_t act_q[$];
    ev_t res_q[$];
    ev_t done_q[$];

    systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .cfg_num_vec     (cfg_num_vec),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_row_idx       (w_row_idx),
        .act_rd_en       (act_rd_en),
        .act_idx         (act_idx),
        .pe_clear_weight (pe_clear_weight),
        .pe_weight_shift (pe_weight_shift),
        .pe_mac_enable   (pe_mac_enable),
        .res_col_valid   (res_col_valid),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cmp_ev(input string name, input bit have, input ev_t e, input int c,
                          input int v);
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL %s: unexpected event at cycle %0d value %0d", name, c, v);
        end else if (e.cyc != c || e.val != v) begin
            failures++;
            $display("FAIL %s: got cycle %0d value %0d expected cycle %0d value %0d",
                     name, c, v, e.cyc, e.val);
        end
    endtask

    // Monitor: every DUT event is matched against the head of its queue.
    always @(negedge clk) begin
        ev_t e;
        bit  h;
        if (reset_n) begin
            if (pe_mac_enable) mac_cnt++;
            if (pe_clear_weight) begin
                h = clr_q.size() > 0;
                if (h) e = clr_q.pop_front();
                cmp_ev("clear", h, e, cyc, 0);
            end
            if (pe_weight_shift) begin
                h = shf_q.size() > 0;
                if (h) e = shf_q.pop_front();
                cmp_ev("shift_row", h, e, cyc, int'(w_row_idx));
            end
            if (act_rd_en) begin
                h = act_q.size() > 0;
                if (h) e = act_q.pop_front();
                cmp_ev("act_idx", h, e, cyc, int'(act_idx));
            end
            if (res_col_valid != '0) begin
                h = res_q.size() > 0;
                if (h) e = res_q.pop_front();
                cmp_ev("res_col_valid", h, e, cyc, int'(res_col_valid));
            end
            if (done) begin
                h = done_q.size() > 0;
                if (h) e = done_q.pop_front();
                cmp_ev("done", h, e, cyc, 0);
            end
        end
    end

    // Expected timeline of one run started in cycle t0, with s stall cycles after beat 0.
    task automatic expect_run(input int t0, input int nv, input int s);
        int le;
        int v;
        clr_q.push_back(mk(t0 + 1, 0));
        for (int b = 0; b < ROWS; b++) begin
            shf_q.push_back(mk(t0 + 2 + b + ((b > 0) ? s : 0), b));
        end
        le = t0 + 2 + s + ROWS;
        if (nv == 0) begin
            done_q.push_back(mk(le, 0));
        end else begin
            for (int i = 0; i < nv; i++) act_q.push_back(mk(le + i, i));
            for (int t = le + ROWS; t < le + ROWS + COLS - 1 + nv; t++) begin
                v = 0;
                for (int c = 0; c < COLS; c++) begin
                    if (t >= le + ROWS + c && t < le + ROWS + c + nv) v |= (1 << c);
                end
                res_q.push_back(mk(t, v));
            end
            done_q.push_back(mk(le + nv + ROWS + COLS - 1, 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input int nv, output int t0);
        step();
        start       = 1'b1;
        cfg_num_vec = CNT_W'(nv);
        t0          = cyc;
        mac_cnt     = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        step();
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic sb_empty(input string name);
        chk(name, clr_q.size() + shf_q.size() + act_q.size() + res_q.size() + done_q.size(), 0);
    endtask

    int t0;

    initial begin
        #12;
        chk("reset_outputs", {w_ready, w_row_idx, act_rd_en, act_idx, pe_clear_weight,
                              pe_mac_enable, res_col_valid, busy, done}, 0);
        reset_n = 1'b1;

        // Test 1: basic run, num_vec=3, no stalls; done lands in cycle 16.
        begin_run(3, t0);
        expect_run(t0, 3, 0);
        step();
        start = 1'b0;
        chk("t1_clear_busy", busy, 1);
        wait_idle("t1_timeout");
        chk("t1_mac_cycles", mac_cnt, 3 + ROWS + COLS - 1);
        sb_empty("t1_sb_empty");

        // Test 2: w_valid low for two cycles after the first beat.
        begin_run(3, t0);
        expect_run(t0, 3, 2);
        step();
        start = 1'b0;
        step();
        step();
        w_valid = 1'b0;
        #1;
        chk("t2_stall_idx_a", w_row_idx, 1);
        chk("t2_stall_shift_a", pe_weight_shift, 0);
        step();
        #1;
        chk("t2_stall_idx_b", w_row_idx, 1);
        chk("t2_stall_ready_b", w_ready, 1);
        step();
        w_valid = 1'b1;
        wait_idle("t2_timeout");
        sb_empty("t2_sb_empty");

        // Test 3: num_vec=0 goes from LOAD straight to DONE.
        begin_run(0, t0);
        expect_run(t0, 0, 0);
        step();
        start = 1'b0;
        wait_idle("t3_timeout");
        chk("t3_mac_cycles", mac_cnt, 0);
        sb_empty("t3_sb_empty");

        // Test 4: abort while act_idx=1, then restart immediately.
        begin_run(5, t0);
        clr_q.push_back(mk(t0 + 1, 0));
        for (int b = 0; b < ROWS; b++) shf_q.push_back(mk(t0 + 2 + b, b));
        act_q.push_back(mk(t0 + 6, 0));
        act_q.push_back(mk(t0 + 7, 1));
        clr_q.push_back(mk(t0 + 8, 0));
        expect_run(t0 + 8, 2, 0);
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t4_idx_at_abort", act_idx, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy_after_abort", busy, 0);
        chk("t4_clear_after_abort", pe_clear_weight, 1);
        chk("t4_done_after_abort", done, 0);
        start       = 1'b1;
        cfg_num_vec = CNT_W'(2);
        step();
        start = 1'b0;
        chk("t4_restart_busy", busy, 1);
        wait_idle("t4_timeout");
        sb_empty("t4_sb_empty");

        // Test 5: start re-pulsed and cfg_num_vec changed mid-run.
        begin_run(3, t0);
        expect_run(t0, 3, 0);
        step();
        start = 1'b0;
        step();
        step();
        start       = 1'b1;
        cfg_num_vec = CNT_W'(7);
        step();
        start = 1'b0;
        wait_idle("t5_timeout");
        step();
        step();
        chk("t5_no_second_run", busy, 0);
        sb_empty("t5_sb_empty");

        // Test 6: reset asserted during LOAD.
        begin_run(3, t0);
        clr_q.push_back(mk(t0 + 1, 0));
        shf_q.push_back(mk(t0 + 2, 0));
        step();
        start = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("t6_async_reset_outputs", {w_ready, w_row_idx, act_rd_en, act_idx, pe_clear_weight,
                                       pe_mac_enable, res_col_valid, busy, done}, 0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("t6_idle_after_reset", busy, 0);
        sb_empty("t6_sb_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
